// File: rtl/nn_run_ctrl.sv
// nn_run_ctrl: Wishbone-slave run controller for one NNgen accelerator run.
//
// The management SoC programs TIMEOUT, writes START, then polls STATUS or
// waits for irq_o. The block pulses acc_start_o, counts run cycles, and ends
// the run on accelerator done, on timeout, or on a software ABORT. Timeout
// and abort hold the accelerator in soft reset for ABORT_CYC cycles.
//
// Ports:
//   wb_clk_i, wb_rst_ni        clock, synchronous active-low reset
//   wbs_cyc_i/stb_i/we_i       Wishbone cycle, strobe, write enable
//   wbs_sel_i[3:0]             byte selects
//   wbs_adr_i[31:0]            byte address (32-byte window at ADDR_BASE)
//   wbs_dat_i[31:0]            write data
//   wbs_ack_o, wbs_dat_o       registered ack, read data (0 when no ack)
//   acc_start_o                one-cycle start pulse to accelerator
//   acc_done_i                 accelerator completion pulse
//   acc_rst_n_o                accelerator soft reset, active-low
//   busy_o                     run in progress
//   irq_o                      level interrupt (user_irq[0])
//
// Register map (adr[4:2]):
//   0 CTRL    {IRQ_EN, ABORT(W1), START(W1)}
//   1 STATUS  {ABORTED, TIMEOUT, DONE (all W1C), BUSY}
//   2 TIMEOUT CNT_W bits, 0 disables
//   3 CYCLES  cycle count of current/last run
//   4 RUNS    16-bit completed-run count
module nn_run_ctrl #(
    parameter logic [31:0]      ADDR_BASE       = 32'h3000_0000,
    parameter int               CNT_W           = 24,
    parameter logic [CNT_W-1:0] DEFAULT_TIMEOUT = CNT_W'(24'h00_FFFF),
    parameter int               ABORT_CYC       = 4
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        acc_start_o,
    input  logic        acc_done_i,
    output logic        acc_rst_n_o,
    output logic        busy_o,
    output logic        irq_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_RUN    = 2'd2,
        S_ABORT  = 2'd3
    } state_t;

    localparam int AW = (ABORT_CYC > 1) ? $clog2(ABORT_CYC) : 1;
    localparam logic [AW-1:0] ABORT_LAST = AW'(ABORT_CYC - 1);

    localparam logic [2:0] R_CTRL    = 3'd0;
    localparam logic [2:0] R_STATUS  = 3'd1;
    localparam logic [2:0] R_TIMEOUT = 3'd2;
    localparam logic [2:0] R_CYCLES  = 3'd3;
    localparam logic [2:0] R_RUNS    = 3'd4;

    state_t state_q, state_d;

    // ------------------------------------------------------------------
    // Wishbone front end
    // ------------------------------------------------------------------
    logic        hit;
    logic        ack_q;
    logic        req_we;
    logic [2:0]  req_reg;
    logic [31:0] req_dat;
    logic [3:0]  req_sel;

    // Suppressing a hit in the ack cycle forces a one-cycle gap between
    // back-to-back accesses.
    assign hit = wbs_cyc_i & wbs_stb_i & ~ack_q &
                 (wbs_adr_i[31:5] == ADDR_BASE[31:5]);

    // The request is captured on the hit so the write can commit at the end
    // of the ack cycle regardless of what the master does with the bus.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            ack_q   <= 1'b0;
            req_we  <= 1'b0;
            req_reg <= 3'd0;
            req_dat <= 32'd0;
            req_sel <= 4'd0;
        end else begin
            ack_q <= hit;
            if (hit) begin
                req_we  <= wbs_we_i;
                req_reg <= wbs_adr_i[4:2];
                req_dat <= wbs_dat_i;
                req_sel <= wbs_sel_i;
            end
        end
    end

    logic       wr;
    logic       wr_ctrl;
    logic       wr_start;
    logic       wr_abort;
    logic [2:0] w1c;     // {ABORTED, TIMEOUT, DONE}

    assign wr       = ack_q & req_we;
    assign wr_ctrl  = wr & (req_reg == R_CTRL) & req_sel[0];
    assign wr_start = wr_ctrl & req_dat[0];
    assign wr_abort = wr_ctrl & req_dat[1];
    assign w1c      = (wr && req_reg == R_STATUS && req_sel[0]) ? req_dat[3:1] : 3'b000;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic             irq_en_q;
    logic             done_q;
    logic             to_q;
    logic             ab_q;
    logic [CNT_W-1:0] timeout_q;
    logic [CNT_W-1:0] cycles_q;
    logic [15:0]      runs_q;
    logic [AW-1:0]    abort_cnt;

    logic set_done;
    logic set_to;
    logic set_ab;
    logic cyc_clr;
    logic cyc_inc;

    // Byte-lane mask for TIMEOUT writes.
    logic [CNT_W-1:0] to_mask;
    always_comb begin
        to_mask = '0;
        for (int i = 0; i < CNT_W; i++) begin
            to_mask[i] = req_sel[i / 8];
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            irq_en_q  <= 1'b0;
            done_q    <= 1'b0;
            to_q      <= 1'b0;
            ab_q      <= 1'b0;
            timeout_q <= DEFAULT_TIMEOUT;
            cycles_q  <= '0;
            runs_q    <= 16'd0;
        end else begin
            if (wr_ctrl) begin
                irq_en_q <= req_dat[2];
            end
            // Set has priority over a same-cycle W1C.
            done_q <= set_done | (done_q & ~w1c[0]);
            to_q   <= set_to   | (to_q   & ~w1c[1]);
            ab_q   <= set_ab   | (ab_q   & ~w1c[2]);
            if (wr && req_reg == R_TIMEOUT) begin
                timeout_q <= (timeout_q & ~to_mask) | (req_dat[CNT_W-1:0] & to_mask);
            end
            if (cyc_clr) begin
                cycles_q <= '0;
            end else if (cyc_inc && cycles_q != '1) begin
                cycles_q <= cycles_q + 1'b1;
            end
            if (set_done) begin
                runs_q <= runs_q + 16'd1;
            end
        end
    end

    // Counts cycles spent in ABORT; parked at 0 everywhere else.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni || state_q != S_ABORT) begin
            abort_cnt <= '0;
        end else begin
            abort_cnt <= abort_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Run FSM
    // ------------------------------------------------------------------
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // CYCLES increments on every edge that enters or stays in RUN, so the
    // first RUN cycle reads 1 and the exit edge leaves the count untouched.
    // The timeout compare therefore sees the value of the current cycle.
    always_comb begin
        state_d  = state_q;
        set_done = 1'b0;
        set_to   = 1'b0;
        set_ab   = 1'b0;
        cyc_clr  = 1'b0;
        cyc_inc  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (wr_start) begin
                    state_d = S_LAUNCH;
                    cyc_clr = 1'b1;
                end
            end
            S_LAUNCH: begin
                state_d = S_RUN;
                cyc_inc = 1'b1;
            end
            S_RUN: begin
                if (acc_done_i) begin
                    set_done = 1'b1;
                    state_d  = S_IDLE;
                end else if (timeout_q != '0 && cycles_q == timeout_q) begin
                    set_to  = 1'b1;
                    state_d = S_ABORT;
                end else if (wr_abort) begin
                    set_ab  = 1'b1;
                    state_d = S_ABORT;
                end else begin
                    cyc_inc = 1'b1;
                end
            end
            S_ABORT: begin
                if (abort_cnt == ABORT_LAST) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are flops decoded from the next state: they track the state
    // register exactly but come out of reset as 0 (acc_rst_n_o included).
    logic start_q;
    logic busy_q;
    logic rst_n_q;
    logic irq_q;

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            rst_n_q <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            start_q <= (state_d == S_LAUNCH);
            busy_q  <= (state_d != S_IDLE);
            rst_n_q <= (state_d != S_ABORT);
            irq_q   <= irq_en_q & (done_q | to_q | ab_q);
        end
    end

    assign acc_start_o = start_q;
    assign busy_o      = busy_q;
    assign acc_rst_n_o = rst_n_q;
    assign irq_o       = irq_q;

    // ------------------------------------------------------------------
    // Read data
    // ------------------------------------------------------------------
    logic [31:0] rdata;
    always_comb begin
        rdata = 32'd0;
        case (req_reg)
            R_CTRL:    rdata[2] = irq_en_q;
            R_STATUS:  rdata[3:0] = {ab_q, to_q, done_q, (state_q != S_IDLE)};
            R_TIMEOUT: rdata[CNT_W-1:0] = timeout_q;
            R_CYCLES:  rdata[CNT_W-1:0] = cycles_q;
            R_RUNS:    rdata[15:0] = runs_q;
            default:   rdata = 32'd0;
        endcase
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = ack_q ? rdata : 32'd0;

    // Address bits below the word and data/select bits beyond the registers
    // are intentionally ignored.
    logic unused_bits;
    assign unused_bits = ^{wbs_adr_i[1:0], wbs_dat_i, wbs_sel_i};

endmodule

// File: tb/tb_nn_run_ctrl.sv
module tb_nn_run_ctrl;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_ni = 1'b0;
    logic        wbs_stb_i = 1'b0;
    logic        wbs_cyc_i = 1'b0;
    logic        wbs_we_i = 1'b0;
    logic [3:0]  wbs_sel_i = 4'h0;
    logic [31:0] wbs_adr_i = 32'h0;
    logic [31:0] wbs_dat_i = 32'h0;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        acc_start_o;
    logic        acc_done_i = 1'b0;
    logic        acc_rst_n_o;
    logic        busy_o;
    logic        irq_o;

    nn_run_ctrl dut (
        .wb_clk_i    (wb_clk_i),
        .wb_rst_ni   (wb_rst_ni),
        .wbs_stb_i   (wbs_stb_i),
        .wbs_cyc_i   (wbs_cyc_i),
        .wbs_we_i    (wbs_we_i),
        .wbs_sel_i   (wbs_sel_i),
        .wbs_adr_i   (wbs_adr_i),
        .wbs_dat_i   (wbs_dat_i),
        .wbs_ack_o   (wbs_ack_o),
        .wbs_dat_o   (wbs_dat_o),
        .acc_start_o (acc_start_o),
        .acc_done_i  (acc_done_i),
        .acc_rst_n_o (acc_rst_n_o),
        .busy_o      (busy_o),
        .irq_o       (irq_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    localparam logic [31:0] B = 32'h3000_0000;

    int total = 0;
    int bad = 0;
    int start_cnt = 0;
    int rstlow_cnt = 0;

    always @(negedge wb_clk_i) if (acc_start_o) start_cnt++;
    always @(negedge wb_clk_i) if (wb_rst_ni && !acc_rst_n_o) rstlow_cnt++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, output logic [31:0] rdat, output logic ok);
        @(negedge wb_clk_i);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
        wbs_adr_i = adr;  wbs_dat_i = dat;  wbs_sel_i = sel;
        ok = 1'b0; rdat = 32'h0;
        for (int i = 0; i < 8; i++) begin
            @(posedge wb_clk_i); #1;
            if (wbs_ack_o) begin
                rdat = wbs_dat_o; ok = 1'b1;
                break;
            end
        end
        @(negedge wb_clk_i);
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    endtask

    task automatic wr(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        logic [31:0] d; logic ok;
        wb_xfer(1'b1, adr, dat, sel, d, ok);
        chk("write ack", {31'd0, ok}, 32'd1);
    endtask

    task automatic rd_chk(input string nm, input logic [31:0] adr, input logic [31:0] exp);
        logic [31:0] d; logic ok;
        wb_xfer(1'b0, adr, 32'h0, 4'hF, d, ok);
        chk({nm, " ack"}, {31'd0, ok}, 32'd1);
        chk(nm, d, exp);
    endtask

    task automatic wait_start();
        logic seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge wb_clk_i);
            if (acc_start_o) begin seen = 1'b1; break; end
        end
        chk("start seen", {31'd0, seen}, 32'd1);
    endtask

    task automatic wait_idle();
        logic idle = 1'b0;
        @(negedge wb_clk_i);
        for (int i = 0; i < 200; i++) begin
            @(negedge wb_clk_i);
            if (!busy_o) begin idle = 1'b1; break; end
        end
        chk("idle reached", {31'd0, idle}, 32'd1);
    endtask

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        exp_ack;
        logic [31:0] exp_dat;
    } vec_t;

    vec_t vt[23];

    initial begin
        int s0, r0;
        logic [31:0] d;
        logic ok;

        vt[0]  = '{1'b0, B + 32'h00, 32'h0,        4'hF, 1'b1, 32'h0000_0000};
        vt[1]  = '{1'b0, B + 32'h04, 32'h0,        4'hF, 1'b1, 32'h0000_0000};
        vt[2]  = '{1'b0, B + 32'h08, 32'h0,        4'hF, 1'b1, 32'h0000_FFFF};
        vt[3]  = '{1'b0, B + 32'h0C, 32'h0,        4'hF, 1'b1, 32'h0000_0000};
        vt[4]  = '{1'b0, B + 32'h10, 32'h0,        4'hF, 1'b1, 32'h0000_0000};
        vt[5]  = '{1'b0, B + 32'h14, 32'h0,        4'hF, 1'b1, 32'h0000_0000};
        vt[6]  = '{1'b0, B + 32'h1C, 32'h0,        4'hF, 1'b1, 32'h0000_0000};
        vt[7]  = '{1'b0, B + 32'h20, 32'h0,        4'hF, 1'b0, 32'h0000_0000};
        vt[8]  = '{1'b0, 32'h2000_0008, 32'h0,     4'hF, 1'b0, 32'h0000_0000};
        vt[9]  = '{1'b1, B + 32'h08, 32'h0012_3456, 4'h1, 1'b1, 32'h0};
        vt[10] = '{1'b0, B + 32'h08, 32'h0,        4'hF, 1'b1, 32'h0000_FF56};
        vt[11] = '{1'b1, B + 32'h08, 32'h00AB_CD00, 4'h6, 1'b1, 32'h0};
        vt[12] = '{1'b0, B + 32'h08, 32'h0,        4'hF, 1'b1, 32'h00AB_CD56};
        vt[13] = '{1'b1, B + 32'h14, 32'hFFFF_FFFF, 4'hF, 1'b1, 32'h0};
        vt[14] = '{1'b0, B + 32'h14, 32'h0,        4'hF, 1'b1, 32'h0000_0000};
        vt[15] = '{1'b1, B + 32'h00, 32'h0000_0004, 4'h1, 1'b1, 32'h0};
        vt[16] = '{1'b0, B + 32'h00, 32'h0,        4'hF, 1'b1, 32'h0000_0004};
        vt[17] = '{1'b1, B + 32'h00, 32'h0000_0000, 4'h2, 1'b1, 32'h0};
        vt[18] = '{1'b0, B + 32'h00, 32'h0,        4'hF, 1'b1, 32'h0000_0004};
        vt[19] = '{1'b1, B + 32'h00, 32'h0000_0000, 4'h1, 1'b1, 32'h0};
        vt[20] = '{1'b0, B + 32'h00, 32'h0,        4'hF, 1'b1, 32'h0000_0000};
        vt[21] = '{1'b1, B + 32'h08, 32'h0000_0000, 4'hF, 1'b1, 32'h0};
        vt[22] = '{1'b0, B + 32'h08, 32'h0,        4'hF, 1'b1, 32'h0000_0000};

        // Reset state
        repeat (3) @(negedge wb_clk_i);
        chk("rst acc_rst_n", {31'd0, acc_rst_n_o}, 32'd0);
        chk("rst busy",      {31'd0, busy_o},      32'd0);
        chk("rst ack",       {31'd0, wbs_ack_o},   32'd0);
        chk("rst irq",       {31'd0, irq_o},       32'd0);
        chk("rst start",     {31'd0, acc_start_o}, 32'd0);
        chk("rst dat",       wbs_dat_o,            32'd0);
        wb_rst_ni = 1'b1;
        @(negedge wb_clk_i);
        chk("post-rst acc_rst_n", {31'd0, acc_rst_n_o}, 32'd1);

        // Register table
        for (int i = 0; i < 23; i++) begin
            wb_xfer(vt[i].we, vt[i].adr, vt[i].dat, vt[i].sel, d, ok);
            chk($sformatf("vec%0d ack", i), {31'd0, ok}, {31'd0, vt[i].exp_ack});
            if (vt[i].exp_ack && !vt[i].we)
                chk($sformatf("vec%0d rdat", i), d, vt[i].exp_dat);
        end

        // Normal run: done 10 cycles after the start pulse
        s0 = start_cnt; r0 = rstlow_cnt;
        wr(B + 32'h00, 32'h5, 4'h1);
        wait_start();
        chk("run busy", {31'd0, busy_o}, 32'd1);
        repeat (10) @(negedge wb_clk_i);
        acc_done_i = 1'b1;
        @(negedge wb_clk_i);
        acc_done_i = 1'b0;
        wait_idle();
        chk("done start pulses", start_cnt - s0, 32'd1);
        chk("done rst pulses", rstlow_cnt - r0, 32'd0);
        rd_chk("done status", B + 32'h04, 32'h2);
        rd_chk("done cycles", B + 32'h0C, 32'd10);
        rd_chk("done runs",   B + 32'h10, 32'd1);
        chk("done irq", {31'd0, irq_o}, 32'd1);
        wr(B + 32'h04, 32'h2, 4'h1);
        repeat (2) @(negedge wb_clk_i);
        chk("irq cleared", {31'd0, irq_o}, 32'd0);

        // Timeout at 5
        wr(B + 32'h08, 32'd5, 4'hF);
        s0 = start_cnt; r0 = rstlow_cnt;
        wr(B + 32'h00, 32'h1, 4'h1);
        wait_idle();
        chk("to start pulses", start_cnt - s0, 32'd1);
        chk("to rst low cycles", rstlow_cnt - r0, 32'd4);
        chk("to busy", {31'd0, busy_o}, 32'd0);
        rd_chk("to status", B + 32'h04, 32'h4);
        rd_chk("to cycles", B + 32'h0C, 32'd5);
        rd_chk("to runs",   B + 32'h10, 32'd1);
        wr(B + 32'h04, 32'hE, 4'h1);

        // Software abort at CYCLES=3, START during ABORT ignored
        wr(B + 32'h08, 32'd0, 4'hF);
        s0 = start_cnt; r0 = rstlow_cnt;
        wr(B + 32'h00, 32'h1, 4'h1);
        repeat (2) @(negedge wb_clk_i);
        wr(B + 32'h00, 32'h2, 4'h1);
        wr(B + 32'h00, 32'h1, 4'h1);
        wait_idle();
        chk("ab start pulses", start_cnt - s0, 32'd1);
        chk("ab rst low cycles", rstlow_cnt - r0, 32'd4);
        rd_chk("ab status", B + 32'h04, 32'h8);
        rd_chk("ab cycles", B + 32'h0C, 32'd3);
        wr(B + 32'h04, 32'h8, 4'h1);
        rd_chk("ab w1c", B + 32'h04, 32'h0);

        // Done coincides with the timeout match at 7
        wr(B + 32'h08, 32'd7, 4'hF);
        r0 = rstlow_cnt;
        wr(B + 32'h00, 32'h1, 4'h1);
        wait_start();
        repeat (7) @(negedge wb_clk_i);
        acc_done_i = 1'b1;
        @(negedge wb_clk_i);
        acc_done_i = 1'b0;
        wait_idle();
        chk("tie rst pulses", rstlow_cnt - r0, 32'd0);
        rd_chk("tie status", B + 32'h04, 32'h2);
        rd_chk("tie cycles", B + 32'h0C, 32'd7);
        rd_chk("tie runs",   B + 32'h10, 32'd2);

        // Reset mid-run at CYCLES=50 with done high
        wr(B + 32'h08, 32'd0, 4'hF);
        wr(B + 32'h00, 32'h1, 4'h1);
        wait_start();
        repeat (50) @(negedge wb_clk_i);
        wb_rst_ni = 1'b0; acc_done_i = 1'b1;
        @(negedge wb_clk_i);
        chk("mid-rst acc_rst_n", {31'd0, acc_rst_n_o}, 32'd0);
        chk("mid-rst busy", {31'd0, busy_o}, 32'd0);
        wb_rst_ni = 1'b1; acc_done_i = 1'b0;
        @(negedge wb_clk_i);
        chk("after-rst acc_rst_n", {31'd0, acc_rst_n_o}, 32'd1);
        rd_chk("rst cycles",  B + 32'h0C, 32'd0);
        rd_chk("rst status",  B + 32'h04, 32'd0);
        rd_chk("rst runs",    B + 32'h10, 32'd0);
        rd_chk("rst timeout", B + 32'h08, 32'h0000_FFFF);
        @(negedge wb_clk_i); acc_done_i = 1'b1;
        @(negedge wb_clk_i); acc_done_i = 1'b0;
        rd_chk("stray done status", B + 32'h04, 32'd0);
        rd_chk("stray done runs",   B + 32'h10, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
